// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO; frames are 1 start, DATA_BITS data (LSB first),
// optional parity (compile with UART_TX_PARITY_EN), STOP_BITS stop bits, sent back-to-back.
`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                          CLK50MHZ_i,
    input  logic                          RST_N_i,
    input  logic [DATA_BITS-1:0]          TX_DATA_i,
    input  logic                          TX_VALID_i,
    output logic                          TX_READY_o,
    output logic                          TX_BUSY_o,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL_o,
    output logic                          TX_o
);

    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = $clog2(STOP_BITS * DIV + 1);
    localparam int BW  = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
    localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_BITS * DIV - 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    localparam logic ODD_L = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
    logic par_q, par_d;
`else
    // Odd/even selection has no meaning without a parity bit.
    if (PARITY_ODD != 0) begin : g_parity_odd_ignored
    end
`endif

    logic [1:0]           rst_sync_q, rst_sync_d;
    logic                 rst_n;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic [LW-1:0]        level_q, level_d;
    logic [AW-1:0]        wr_q, wr_d;
    logic [AW-1:0]        rd_q, rd_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];

    logic                 push_s;
    logic                 pop_s;
    logic                 load_s;
    logic [DATA_BITS-1:0] head_s;
    logic                 empty_s;

    // Reset synchroniser next-state: shifts ones in after release.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchroniser: asserts immediately, releases two clocks later.
    always_ff @(posedge CLK50MHZ_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n   = rst_sync_q[1];
    assign head_s  = mem_q[rd_q];
    assign empty_s = (level_q == {LW{1'b0}});
    assign push_s  = TX_VALID_i && ready_q;

    // Transmit FSM: bit timing, shifting and FIFO pop requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        load_s  = 1'b0;
        pop_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!empty_s) begin
                    load_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == {CW{1'b0}}) begin
                    cnt_d   = BIT_LOAD;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == {CW{1'b0}}) begin
                    cnt_d   = BIT_LOAD;
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        cnt_d   = STOP_LOAD;
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
                if (cnt_q == {CW{1'b0}}) begin
                    tx_d    = 1'b1;
                    cnt_d   = STOP_LOAD;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
`else
                tx_d    = 1'b1;
                state_d = ST_IDLE;
`endif
            end
            ST_STOP: begin
                if (cnt_q == {CW{1'b0}}) begin
                    if (!empty_s) begin
                        load_s = 1'b1;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        // Frame start is shared by IDLE and the gapless STOP->START hand-over.
        if (load_s) begin
            pop_s   = 1'b1;
            shift_d = head_s;
            cnt_d   = BIT_LOAD;
            bit_d   = {BW{1'b0}};
            tx_d    = 1'b0;
            state_d = ST_START;
`ifdef UART_TX_PARITY_EN
            par_d   = parity_bit(head_s, ODD_L);
`endif
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push_s) begin
            mem_d[wr_q] = TX_DATA_i;
            wr_d        = wr_q + AW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_q + AW'(1);
        end else begin
            rd_d = rd_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Status outputs are registered from next-state values so they line up with state/level.
    always_comb begin
        busy_d  = (state_d != ST_IDLE) || (level_d != {LW{1'b0}});
        ready_d = (level_d != DEPTH_L);
    end

    // State register for FSM, FIFO and registered outputs.
    always_ff @(posedge CLK50MHZ_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            bit_q   <= {BW{1'b0}};
            shift_q <= {DATA_BITS{1'b0}};
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            level_q <= {LW{1'b0}};
            wr_q    <= {AW{1'b0}};
            rd_q    <= {AW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {DATA_BITS{1'b0}};
            end
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            level_q <= level_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            mem_q   <= mem_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign TX_o         = tx_q;
    assign TX_READY_o   = ready_q;
    assign TX_BUSY_o    = busy_q;
    assign FIFO_LEVEL_o = level_q;

endmodule
